// File: rtl/bram_run_scheduler.sv
// bram_run_scheduler: queues run-count jobs and issues them one at a time to the BRAM accessor
// Ports:
//   clk, reset_n                 rising-edge clock, asynchronous active-low reset
//   job_valid_i, job_count_i     host job presentation; job_ready_o = FIFO has room and no clear
//   clear_i                      synchronous flush of pending jobs and sticky flags
//   start_run_o, run_count_o     one-cycle start pulse and its count to the accessor
//   acc_idle_i, acc_done_i       accessor status
//   busy_o, pending_o            FSM not idle, pending FIFO occupancy (in-flight job excluded)
//   jobs_done_o                  wrapping completed-job counter
//   err_zero_o, timeout_o        sticky: zero-count job discarded, accessor done never came
//   irq_o                        one-cycle pulse when the last queued job completes
module bram_run_scheduler #(
   parameter int CNT_BIT     = 31,
   parameter int JOB_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int DONE_CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       job_valid_i,
   input  logic [CNT_BIT-1:0]         job_count_i,
   output logic                       job_ready_o,
   input  logic                       clear_i,
   output logic                       start_run_o,
   output logic [CNT_BIT-1:0]         run_count_o,
   input  logic                       acc_idle_i,
   input  logic                       acc_done_i,
   output logic                       busy_o,
   output logic [$clog2(JOB_DEPTH):0] pending_o,
   output logic [DONE_CNT_W-1:0]      jobs_done_o,
   output logic                       err_zero_o,
   output logic                       timeout_o,
   output logic                       irq_o
);
   localparam int AW = $clog2(JOB_DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   state_t state_q, state_d;
   logic [CNT_BIT-1:0] mem_q [JOB_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [CNT_BIT-1:0] run_count_q, run_count_d, head;
   logic [DONE_CNT_W-1:0] jobs_done_q, jobs_done_d;
   logic start_run_q, start_run_d, busy_q, busy_d, irq_q, irq_d;
   logic err_zero_q, err_zero_d, timeout_q, timeout_d;
   logic empty, push, pop, issue_go, done_hit, tmo_hit;
   assign head        = mem_q[rd_ptr_q];
   assign empty       = cnt_q == '0;
   assign job_ready_o = cnt_q != PW'(JOB_DEPTH) && !clear_i;
   assign push        = job_valid_i && job_ready_o;
   assign pop         = state_q == S_ISSUE;
   assign issue_go    = state_q == S_IDLE && state_d == S_ISSUE;
   assign done_hit    = state_q == S_WAIT && acc_done_i;
   assign tmo_hit     = state_q == S_WAIT && !acc_done_i && timer_q == TW'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state_q <= S_IDLE;
      else state_q <= state_d;
   // A flush in the same cycle as the idle check must not launch a job being flushed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!empty && acc_idle_i && !clear_i) state_d = S_ISSUE;
         S_ISSUE: state_d = start_run_q ? S_WAIT : S_IDLE;
         S_WAIT:  if (done_hit || tmo_hit) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   // start_run_q doubles as the "head was non-zero" flag while in S_ISSUE.
   always_comb begin
      start_run_d = issue_go && head != '0;
      run_count_d = start_run_d ? head : '0;
      busy_d      = state_d != S_IDLE;
      timer_d     = state_q == S_WAIT ? timer_q + TW'(1) : '0;
      jobs_done_d = jobs_done_q + DONE_CNT_W'(done_hit);
      irq_d       = done_hit && empty;
      err_zero_d  = !clear_i && (err_zero_q || (pop && !start_run_q));
      timeout_d   = !clear_i && (timeout_q || tmo_hit);
      wr_ptr_d    = clear_i ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d    = clear_i ? '0 : rd_ptr_q + AW'(pop);
      cnt_d       = clear_i ? '0 : cnt_q + PW'(push) - PW'(pop);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         timer_q     <= '0;
         start_run_q <= 1'b0;
         run_count_q <= '0;
         busy_q      <= 1'b0;
         jobs_done_q <= '0;
         irq_q       <= 1'b0;
         err_zero_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         start_run_q <= start_run_d;
         run_count_q <= run_count_d;
         busy_q      <= busy_d;
         jobs_done_q <= jobs_done_d;
         irq_q       <= irq_d;
         err_zero_q  <= err_zero_d;
         timeout_q   <= timeout_d;
      end
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= job_count_i;
   assign start_run_o = start_run_q;
   assign run_count_o = run_count_q;
   assign busy_o      = busy_q;
   assign pending_o   = cnt_q;
   assign jobs_done_o = jobs_done_q;
   assign err_zero_o  = err_zero_q;
   assign timeout_o   = timeout_q;
   assign irq_o       = irq_q;
endmodule

// File: tb/tb_bram_run_scheduler.sv
// tb_bram_run_scheduler: directed and randomized checks of the job scheduler against a queue-based model
module tb_bram_run_scheduler;
   localparam int CNT_BIT = 31;
   localparam int DEPTH = 4;
   localparam int TO = 300;
   localparam int DW = 16;
   logic clk = 0, reset_n = 0, job_valid_i = 0, clear_i = 0, acc_idle_i = 1, acc_done_i = 0;
   logic [CNT_BIT-1:0] job_count_i = '0;
   logic job_ready_o, start_run_o, busy_o, err_zero_o, timeout_o, irq_o;
   logic [CNT_BIT-1:0] run_count_o;
   logic [$clog2(DEPTH):0] pending_o;
   logic [DW-1:0] jobs_done_o;
   int n_chk = 0, n_err = 0;
   int issued[$];
   int irq_cnt = 0, cd = 0, done_delay = 3, max_pend = 0, exp_done = 0;
   bit auto_done = 1, dbl_pulse = 0, rc_bad = 0, prev_start = 0;
   always #5 clk = ~clk;
   bram_run_scheduler #(.CNT_BIT(CNT_BIT), .JOB_DEPTH(DEPTH), .TIMEOUT_CYC(TO), .DONE_CNT_W(DW)) dut (
      .clk(clk), .reset_n(reset_n), .job_valid_i(job_valid_i), .job_count_i(job_count_i),
      .job_ready_o(job_ready_o), .clear_i(clear_i), .start_run_o(start_run_o), .run_count_o(run_count_o),
      .acc_idle_i(acc_idle_i), .acc_done_i(acc_done_i), .busy_o(busy_o), .pending_o(pending_o),
      .jobs_done_o(jobs_done_o), .err_zero_o(err_zero_o), .timeout_o(timeout_o), .irq_o(irq_o));
   // One clock: observe outputs at the falling edge, then play the accessor (done after done_delay cycles).
   task automatic tick();
      @(negedge clk);
      if (start_run_o) issued.push_back(int'(run_count_o));
      if (irq_o) irq_cnt++;
      if (start_run_o && prev_start) dbl_pulse = 1;
      if (!start_run_o && run_count_o != '0) rc_bad = 1;
      if (int'(pending_o) > max_pend) max_pend = int'(pending_o);
      prev_start = start_run_o;
      acc_done_i = 0;
      if (cd > 0) begin
         cd--;
         acc_done_i = cd == 0;
      end
      if (start_run_o && auto_done) cd = done_delay;
   endtask
   task automatic push(input int c);
      job_valid_i = 1;
      job_count_i = CNT_BIT'(c);
      tick();
      job_valid_i = 0;
   endtask
   task automatic wait_jobs(input int target, output bit ok);
      for (int i = 0; i < 3000 && jobs_done_o != DW'(target); i++) tick();
      ok = jobs_done_o == DW'(target);
   endtask
   task automatic test_reset();
      reset_n = 0;
      repeat (3) @(negedge clk);
      n_chk++; if ({start_run_o, busy_o, err_zero_o, timeout_o, irq_o} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {start_run_o, busy_o, err_zero_o, timeout_o, irq_o}); end
      n_chk++; if (run_count_o !== '0) begin n_err++; $display("FAIL reset_run_count: got %0d want 0", run_count_o); end
      n_chk++; if (pending_o !== '0) begin n_err++; $display("FAIL reset_pending: got %0d want 0", pending_o); end
      n_chk++; if (jobs_done_o !== '0) begin n_err++; $display("FAIL reset_jobs_done: got %0d want 0", jobs_done_o); end
      reset_n = 1;
      tick();
      n_chk++; if (job_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", job_ready_o); end
   endtask
   task automatic test_single();
      bit ok;
      issued.delete(); irq_cnt = 0; auto_done = 1; done_delay = 258;
      push(255);
      n_chk++; if (start_run_o !== 1'b0 || pending_o !== 3'd1) begin n_err++; $display("FAIL single_push: start %b pending %0d want 0 1", start_run_o, pending_o); end
      tick();
      n_chk++; if (start_run_o !== 1'b1 || run_count_o !== 31'd255) begin n_err++; $display("FAIL single_start: start %b count %0d want 1 255", start_run_o, run_count_o); end
      tick();
      n_chk++; if (start_run_o !== 1'b0 || run_count_o !== '0 || pending_o !== '0 || busy_o !== 1'b1) begin n_err++; $display("FAIL single_after: start %b count %0d pending %0d busy %b want 0 0 0 1", start_run_o, run_count_o, pending_o, busy_o); end
      exp_done = 1;
      wait_jobs(exp_done, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL single_done: jobs_done %0d want %0d", jobs_done_o, exp_done); end
      n_chk++; if (irq_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL single_irq: irq %b busy %b want 1 0", irq_o, busy_o); end
      tick();
      n_chk++; if (irq_o !== 1'b0 || irq_cnt != 1) begin n_err++; $display("FAIL single_irq_pulse: irq %b count %0d want 0 1", irq_o, irq_cnt); end
      n_chk++; if (issued.size() != 1 || issued[0] != 255) begin n_err++; $display("FAIL single_issued: %0d starts want 1 of 255", issued.size()); end
   endtask
   task automatic test_fill();
      int want[5] = '{10, 20, 30, 40, 50};
      bit ok, seen = 0;
      int g;
      issued.delete(); irq_cnt = 0; acc_idle_i = 0; auto_done = 1; done_delay = 3;
      for (int i = 0; i < 4; i++) push(want[i]);
      n_chk++; if (job_ready_o !== 1'b0 || pending_o !== 3'd4) begin n_err++; $display("FAIL fill_full: ready %b pending %0d want 0 4", job_ready_o, pending_o); end
      job_valid_i = 1; job_count_i = 31'd50;
      tick();
      n_chk++; if (pending_o !== 3'd4 || issued.size() != 0) begin n_err++; $display("FAIL fill_refuse: pending %0d starts %0d want 4 0", pending_o, issued.size()); end
      acc_idle_i = 1;
      for (g = 0; g < 20 && !job_ready_o; g++) begin
         tick();
         if (start_run_o && !seen) begin
            seen = 1;
            n_chk++; if (job_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_no_bypass: ready %b during issue want 0", job_ready_o); end
         end
      end
      n_chk++; if (!job_ready_o) begin n_err++; $display("FAIL fill_ready_return: ready %b want 1", job_ready_o); end
      tick();
      job_valid_i = 0;
      n_chk++; if (pending_o !== 3'd4) begin n_err++; $display("FAIL fill_accept50: pending %0d want 4", pending_o); end
      exp_done += 5;
      wait_jobs(exp_done, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL fill_done: jobs_done %0d want %0d", jobs_done_o, exp_done); end
      ok = issued.size() == 5;
      for (int i = 0; i < 5 && ok; i++) ok = issued[i] == want[i];
      n_chk++; if (!ok) begin n_err++; $display("FAIL fill_order: %0d starts, order wrong or incomplete, want 10 20 30 40 50", issued.size()); end
      tick();
      n_chk++; if (irq_cnt != 1) begin n_err++; $display("FAIL fill_irq: %0d pulses want 1", irq_cnt); end
   endtask
   task automatic test_zero();
      bit ok;
      issued.delete(); auto_done = 1; done_delay = 3;
      push(0); push(7);
      exp_done++;
      wait_jobs(exp_done, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL zero_done: jobs_done %0d want %0d", jobs_done_o, exp_done); end
      n_chk++; if (issued.size() != 1 || issued[0] != 7) begin n_err++; $display("FAIL zero_issued: %0d starts want single 7", issued.size()); end
      n_chk++; if (err_zero_o !== 1'b1) begin n_err++; $display("FAIL zero_flag: got %b want 1", err_zero_o); end
      clear_i = 1;
      #1;
      n_chk++; if (job_ready_o !== 1'b0) begin n_err++; $display("FAIL zero_clear_ready: got %b want 0", job_ready_o); end
      tick();
      clear_i = 0;
      n_chk++; if (err_zero_o !== 1'b0) begin n_err++; $display("FAIL zero_clear_flag: got %b want 0", err_zero_o); end
   endtask
   task automatic test_timeout();
      bit ok;
      issued.delete(); auto_done = 0;
      push(3); push(9);
      for (int g = 0; g < 10 && issued.size() == 0; g++) tick();
      repeat (TO) tick();
      n_chk++; if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL timeout_early: timeout %b busy %b want 0 1", timeout_o, busy_o); end
      tick();
      auto_done = 1;
      n_chk++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", timeout_o); end
      n_chk++; if (jobs_done_o !== DW'(exp_done)) begin n_err++; $display("FAIL timeout_not_counted: jobs_done %0d want %0d", jobs_done_o, exp_done); end
      exp_done++;
      wait_jobs(exp_done, ok);
      n_chk++; if (!ok || issued.size() != 2 || issued[0] != 3 || issued[1] != 9) begin n_err++; $display("FAIL timeout_next: jobs_done %0d starts %0d want %0d 2 (3 then 9)", jobs_done_o, issued.size(), exp_done); end
      clear_i = 1;
      tick();
      clear_i = 0;
      n_chk++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b want 0", timeout_o); end
   endtask
   task automatic test_clear_busy();
      issued.delete(); irq_cnt = 0; auto_done = 0;
      push(5); push(6); push(7); push(8);
      n_chk++; if (pending_o !== 3'd3 || busy_o !== 1'b1) begin n_err++; $display("FAIL clr_setup: pending %0d busy %b want 3 1", pending_o, busy_o); end
      job_valid_i = 1; job_count_i = 31'd99; clear_i = 1;
      #1;
      n_chk++; if (job_ready_o !== 1'b0) begin n_err++; $display("FAIL clr_ready: got %b want 0", job_ready_o); end
      tick();
      clear_i = 0; job_valid_i = 0;
      n_chk++; if (pending_o !== '0 || busy_o !== 1'b1) begin n_err++; $display("FAIL clr_flush: pending %0d busy %b want 0 1", pending_o, busy_o); end
      acc_done_i = 1;
      tick();
      exp_done++;
      n_chk++; if (jobs_done_o !== DW'(exp_done) || irq_o !== 1'b1) begin n_err++; $display("FAIL clr_inflight_done: jobs_done %0d irq %b want %0d 1", jobs_done_o, irq_o, exp_done); end
      repeat (5) tick();
      n_chk++; if (issued.size() != 1 || busy_o !== 1'b0 || pending_o !== '0) begin n_err++; $display("FAIL clr_quiet: starts %0d busy %b pending %0d want 1 0 0", issued.size(), busy_o, pending_o); end
   endtask
   task automatic test_async_reset();
      auto_done = 0;
      push(11); push(12); push(13);
      tick();
      #2 reset_n = 0;
      #1;
      n_chk++; if ({start_run_o, busy_o, err_zero_o, timeout_o, irq_o} !== 5'b0 || run_count_o !== '0) begin n_err++; $display("FAIL areset_flags: flags %b count %0d want 00000 0", {start_run_o, busy_o, err_zero_o, timeout_o, irq_o}, run_count_o); end
      n_chk++; if (pending_o !== '0 || jobs_done_o !== '0) begin n_err++; $display("FAIL areset_counts: pending %0d jobs_done %0d want 0 0", pending_o, jobs_done_o); end
      @(negedge clk);
      reset_n = 1; cd = 0; exp_done = 0; prev_start = 0;
      tick();
      n_chk++; if (job_ready_o !== 1'b1 || busy_o !== 1'b0 || pending_o !== '0) begin n_err++; $display("FAIL areset_release: ready %b busy %b pending %0d want 1 0 0", job_ready_o, busy_o, pending_o); end
   endtask
   task automatic test_random();
      int exp_q[$];
      int zeros = 0, c, g;
      bit ok;
      issued.delete(); irq_cnt = 0; auto_done = 1; max_pend = 0; dbl_pulse = 0; rc_bad = 0;
      for (int j = 0; j < 40; j++) begin
         repeat ($urandom_range(0, 4)) begin
            acc_idle_i = $urandom_range(0, 3) != 0;
            tick();
         end
         acc_idle_i = 1;
         done_delay = int'($urandom_range(1, 12));
         c = (j == 39 || $urandom_range(0, 6) != 0) ? int'($urandom_range(1, 1000)) : 0;
         job_valid_i = 1; job_count_i = CNT_BIT'(c);
         for (g = 0; g < 200 && !job_ready_o; g++) tick();
         n_chk++; if (!job_ready_o) begin n_err++; $display("FAIL rand_ready: job %0d never accepted", j); end
         tick();
         job_valid_i = 0;
         if (c == 0) zeros++;
         else exp_q.push_back(c);
      end
      exp_done += exp_q.size();
      wait_jobs(exp_done, ok);
      n_chk++; if (!ok) begin n_err++; $display("FAIL rand_done: jobs_done %0d want %0d", jobs_done_o, exp_done); end
      ok = issued.size() == exp_q.size();
      for (int i = 0; i < exp_q.size() && ok; i++) ok = issued[i] == exp_q[i];
      n_chk++; if (!ok) begin n_err++; $display("FAIL rand_order: %0d starts want %0d in push order", issued.size(), exp_q.size()); end
      n_chk++; if (err_zero_o !== (zeros > 0) || timeout_o !== 1'b0) begin n_err++; $display("FAIL rand_flags: err_zero %b timeout %b want %b 0", err_zero_o, timeout_o, zeros > 0); end
      n_chk++; if (irq_cnt < 1 || irq_cnt > exp_q.size()) begin n_err++; $display("FAIL rand_irq: %0d pulses want 1..%0d", irq_cnt, exp_q.size()); end
      n_chk++; if (max_pend > DEPTH || dbl_pulse || rc_bad) begin n_err++; $display("FAIL rand_invariants: max pending %0d double pulse %b stray count %b want <=4 0 0", max_pend, dbl_pulse, rc_bad); end
      n_chk++; if (busy_o !== 1'b0 || pending_o !== '0) begin n_err++; $display("FAIL rand_drain: busy %b pending %0d want 0 0", busy_o, pending_o); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_fill();
      test_zero();
      test_timeout();
      test_clear_busy();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/bram_run_scheduler.md
Name: bram_run_scheduler

Overview:
- Job sequencer in front of the BRAM accessor (BRAM0 32-bit read, BRAM1 64-bit write).
- Accepts run-count job descriptors from the host register block into a small FIFO.
- Issues each job to the accessor as a one-cycle start_run pulse plus run_count, then waits for the accessor's done.
- Reports status counters and a drain interrupt, so the host can queue several transfers back to back without polling.

Parameters:
- CNT_BIT, 31: width of a job run count; matches the accessor run_count_i.
- JOB_DEPTH, 4: pending-job FIFO depth; power of two, at least 2.
- TIMEOUT_CYC, 1024: cycles allowed between the start pulse and the accessor done before the job is abandoned.
- DONE_CNT_W, 16: width of the completed-job counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- job_valid_i  in  1  host presents a job.
- job_count_i  in  CNT_BIT  run count of the presented job.
- job_ready_o  out  1  FIFO can accept a job.
- clear_i  in  1  synchronous flush of pending jobs and sticky flags.
- start_run_o  out  1  one-cycle start pulse to the accessor start_run_i.
- run_count_o  out  CNT_BIT  count to the accessor run_count_i; valid only while start_run_o is high, 0 otherwise.
- acc_idle_i  in  1  accessor idle_o.
- acc_done_i  in  1  accessor done_o.
- busy_o  out  1  high in any state other than S_IDLE.
- pending_o  out  $clog2(JOB_DEPTH)+1  FIFO occupancy.
- jobs_done_o  out  DONE_CNT_W  completed-job counter; wraps to 0.
- err_zero_o  out  1  sticky: a zero-count job was discarded.
- timeout_o  out  1  sticky: accessor done not seen within TIMEOUT_CYC.
- irq_o  out  1  one-cycle pulse when the last queued job completes.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FIFO emptied, state S_IDLE, timer cleared.
  - Outputs: start_run_o=0, run_count_o=0, busy_o=0, pending_o=0, jobs_done_o=0, err_zero_o=0, timeout_o=0, irq_o=0.
  - job_ready_o=1 once reset_n is released.
- Push rule:
  - job_ready_o = !full && !clear_i.
  - A push occurs on an edge where job_valid_i && job_ready_o.
  - There is no bypass: a full FIFO refuses pushes even in the cycle it pops.
- State machine, all outputs registered:
  - S_IDLE: if FIFO is non-empty and acc_idle_i=1 -> S_ISSUE.
  - S_ISSUE (one cycle): start_run_o=1, run_count_o=head count; head popped at exit.
    - Head count == 0: start_run_o stays 0, err_zero_o set, job discarded, -> S_IDLE.
    - Otherwise -> S_WAIT.
  - S_WAIT: timer increments every cycle.
    - acc_done_i=1 -> jobs_done_o+1, -> S_IDLE. If the FIFO is empty at that edge, irq_o pulses for the next cycle.
    - Timer reaches TIMEOUT_CYC-1 with no done -> timeout_o set, job not counted, -> S_IDLE.
- Latency:
  - Push edge k into an empty FIFO with the accessor idle: S_ISSUE entered at edge k+1, start_run_o high for cycle k+1..k+2.
  - Back-to-back jobs: the next start comes no sooner than 2 cycles after acc_done_i.
- pending_o excludes the in-flight job; it decrements at the S_ISSUE exit edge.
- clear_i:
  - Empties the FIFO and clears err_zero_o and timeout_o.
  - Does not abort a job in S_WAIT, and does not clear jobs_done_o.
  - A push in the same cycle is refused (ready is low).
  - clear_i while in S_ISSUE: the pulse still completes, and the head was already latched into run_count_o.
- acc_done_i outside S_WAIT is ignored.
- Reset mid-job: the scheduler returns to S_IDLE immediately; the accessor is expected to be reset by the same reset_n.

Test Plan:
- Single job: push count=255 after reset -> start_run_o high exactly 1 cycle with run_count_o=255, 2 edges after the push; done at +260 -> jobs_done_o=1, irq_o one pulse, busy_o=0.
- Fill and back-pressure: push 5 jobs (10,20,30,40,50) while acc_idle_i=0 -> job_ready_o drops after the 4th, pending_o=4. Release idle and complete each job -> run_count_o sequence is 10,20,30,40, then 50 is accepted. jobs_done_o=5 and a single irq_o pulse at the end.
- Zero job: push 0 then 7 -> no start pulse for 0, err_zero_o=1, next start carries 7; clear_i -> err_zero_o=0.
- Timeout: TIMEOUT_CYC=16, push 3, never assert done -> timeout_o=1 after 16 cycles in S_WAIT, jobs_done_o unchanged, next queued job issues.
- Clear while busy: 3 jobs queued, one in S_WAIT, assert clear_i with job_valid_i=1 -> pending_o=0, push refused. In-flight done still increments jobs_done_o and pulses irq_o.
- Async reset mid-S_WAIT: reset_n low between edges -> all outputs at reset values immediately, without waiting for a clock edge.
